// File: rtl/reservation_station.sv
// reservation_station: holds dispatched ALU ops, snoops ALU/LSB CDB to resolve operands, issues lowest ready entry per cycle (ports: Sys_* control, DPRS_* dispatch in, RSDP_full out, CDBRS_* broadcasts in, RSALU_* issue out)
module reservation_station #(
  parameter int RS_SIZE = 8,
  parameter int RS_WIDTH = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int RoB_WIDTH = 8,
  parameter int EX_RoB_WIDTH = 9,
  parameter logic [EX_RoB_WIDTH-1:0] NON_DEP = {1'b1, {RoB_WIDTH{1'b0}}}
) (
  input  logic                    Sys_clk,
  input  logic                    Sys_rst,
  input  logic                    Sys_rdy,
  input  logic                    RoBRS_pre_judge,
  input  logic                    DPRS_en,
  input  logic [ADDR_WIDTH-1:0]   DPRS_pc,
  input  logic [EX_RoB_WIDTH-1:0] DPRS_Qj,
  input  logic [EX_RoB_WIDTH-1:0] DPRS_Qk,
  input  logic [31:0]             DPRS_Vj,
  input  logic [31:0]             DPRS_Vk,
  input  logic [31:0]             DPRS_imm,
  input  logic [6:0]              DPRS_opcode,
  input  logic [RoB_WIDTH-1:0]    DPRS_RoB_index,
  output logic                    RSDP_full,
  input  logic                    CDBRS_ALU_en,
  input  logic [RoB_WIDTH-1:0]    CDBRS_ALU_RoB_index,
  input  logic [31:0]             CDBRS_ALU_value,
  input  logic                    CDBRS_LSB_en,
  input  logic [RoB_WIDTH-1:0]    CDBRS_LSB_RoB_index,
  input  logic [31:0]             CDBRS_LSB_value,
  output logic                    RSALU_en,
  output logic [6:0]              RSALU_opcode,
  output logic [ADDR_WIDTH-1:0]   RSALU_pc,
  output logic [31:0]             RSALU_Vj,
  output logic [31:0]             RSALU_Vk,
  output logic [31:0]             RSALU_imm,
  output logic [RoB_WIDTH-1:0]    RSALU_RoB_index
);
  localparam logic [RS_WIDTH:0] FULL_AT = (RS_WIDTH+1)'(RS_SIZE-1);
  logic                    busy_q [RS_SIZE];
  logic [6:0]              op_q   [RS_SIZE];
  logic [ADDR_WIDTH-1:0]   pc_q   [RS_SIZE];
  logic [31:0]             imm_q  [RS_SIZE];
  logic [31:0]             vj_q   [RS_SIZE];
  logic [31:0]             vk_q   [RS_SIZE];
  logic [EX_RoB_WIDTH-1:0] qj_q   [RS_SIZE];
  logic [EX_RoB_WIDTH-1:0] qk_q   [RS_SIZE];
  logic [RoB_WIDTH-1:0]    rob_q  [RS_SIZE];
  logic [RS_WIDTH:0]       cnt;
  logic                    free_ok, iss_ok;
  logic [RS_WIDTH-1:0]     free_idx, iss_idx;
  function automatic logic [EX_RoB_WIDTH+31:0] snoop(input logic [EX_RoB_WIDTH-1:0] q, input logic [31:0] v);
    snoop = (CDBRS_ALU_en && q == {1'b0, CDBRS_ALU_RoB_index}) ? {NON_DEP, CDBRS_ALU_value}
          : (CDBRS_LSB_en && q == {1'b0, CDBRS_LSB_RoB_index}) ? {NON_DEP, CDBRS_LSB_value} : {q, v};
  endfunction
  always_comb begin
    cnt = '0;
    free_ok = 1'b0;
    free_idx = '0;
    iss_ok = 1'b0;
    iss_idx = '0;
    for (int i = RS_SIZE-1; i >= 0; i--) begin
      cnt = cnt + (RS_WIDTH+1)'(busy_q[i]);
      if (!busy_q[i]) begin
        free_ok = 1'b1;
        free_idx = RS_WIDTH'(i);
      end
      if (busy_q[i] && qj_q[i] == NON_DEP && qk_q[i] == NON_DEP) begin
        iss_ok = 1'b1;
        iss_idx = RS_WIDTH'(i);
      end
    end
  end
  assign RSDP_full = cnt >= FULL_AT;
  always_ff @(posedge Sys_clk) begin
    if (Sys_rst || !RoBRS_pre_judge) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        busy_q[i] <= 1'b0;
        qj_q[i] <= NON_DEP;
        qk_q[i] <= NON_DEP;
      end
      RSALU_en <= 1'b0;
      RSALU_opcode <= '0;
      RSALU_pc <= '0;
      RSALU_Vj <= '0;
      RSALU_Vk <= '0;
      RSALU_imm <= '0;
      RSALU_RoB_index <= '0;
    end else if (Sys_rdy) begin
      for (int i = 0; i < RS_SIZE; i++)
        if (busy_q[i]) begin
          {qj_q[i], vj_q[i]} <= snoop(qj_q[i], vj_q[i]);
          {qk_q[i], vk_q[i]} <= snoop(qk_q[i], vk_q[i]);
        end
      RSALU_en <= iss_ok;
      if (iss_ok) begin
        busy_q[iss_idx] <= 1'b0;
        RSALU_opcode <= op_q[iss_idx];
        RSALU_pc <= pc_q[iss_idx];
        RSALU_Vj <= vj_q[iss_idx];
        RSALU_Vk <= vk_q[iss_idx];
        RSALU_imm <= imm_q[iss_idx];
        RSALU_RoB_index <= rob_q[iss_idx];
      end
      if (DPRS_en && free_ok) begin
        busy_q[free_idx] <= 1'b1;
        op_q[free_idx] <= DPRS_opcode;
        pc_q[free_idx] <= DPRS_pc;
        imm_q[free_idx] <= DPRS_imm;
        rob_q[free_idx] <= DPRS_RoB_index;
        {qj_q[free_idx], vj_q[free_idx]} <= snoop(DPRS_Qj, DPRS_Vj);
        {qk_q[free_idx], vk_q[free_idx]} <= snoop(DPRS_Qk, DPRS_Vk);
      end
    end else begin
      RSALU_en <= 1'b0;
    end
  end
  always_ff @(posedge Sys_clk)
    if (!Sys_rst && RoBRS_pre_judge && Sys_rdy && DPRS_en)
      assert (free_ok);
endmodule
